// File: rtl/uart_tx_serializer_if.sv
// Producer-side handshake into the UART transmitter: one word per
// cycle where tx_valid and tx_ready are both high.
interface uart_tx_serializer_if #(
  parameter int WORD_LENGTH = 8
);
  logic [WORD_LENGTH-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, WORD_LENGTH data bits LSB-first,
// even parity, one stop bit. A one-word holding register lets the next
// word be accepted while the current frame shifts out, so frames can
// run back-to-back.
module uart_tx_serializer #(
  parameter int CLK_RATE    = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int WORD_LENGTH = 8
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  uart_tx_serializer_if.slave  tx_if,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 frame_done
);

  localparam int DIV    = CLK_RATE / BAUD;
  localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W  = $clog2(WORD_LENGTH) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_q;
  logic [BIT_W-1:0]       bit_q;
  logic                   hold_full;
  logic [WORD_LENGTH-1:0] hold_data;
  logic [WORD_LENGTH:0]   shifter;     // {parity, data}
  logic                   ready_q;
  logic                   bit_end;
  logic                   accept;
  logic                   drain;
  logic                   line_bit;

  assign tx_if.tx_ready = ready_q;
  assign bit_end        = (baud_q == BAUD_LAST);
  assign accept         = tx_if.tx_valid & ready_q;

  // Next-state logic; drain moves the held word into the shifter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    drain   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_full) begin
          drain   = 1'b1;
          state_d = START;
        end
      end
      START:  if (bit_end) state_d = DATA;
      DATA:   if (bit_end && (bit_q == BIT_LAST)) state_d = PARITY;
      PARITY: if (bit_end) state_d = STOP;
      STOP: begin
        if (bit_end) begin
          if (hold_full) begin
            drain   = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the bit currently being timed by the FSM.
  always_comb begin
    line_bit = 1'b1;
    case (state_q)
      START:   line_bit = 1'b0;
      DATA:    line_bit = shifter[bit_q];
      PARITY:  line_bit = shifter[WORD_LENGTH];
      default: line_bit = 1'b1;
    endcase
  end

  // FSM state plus baud and bit counters.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      // NOTE: sequential state is updated with <= so every register samples pre-edge values.
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE || bit_end) baud_q <= '0;
      else                            baud_q <= baud_q + 1'b1;
      if (state_q == START && bit_end)
        bit_q <= '0;
      else if (state_q == DATA && bit_end && bit_q != BIT_LAST)
        bit_q <= bit_q + 1'b1;
    end
  end

  // Holding-register occupancy; ready stays low through the drain cycle.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      hold_full <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      if (accept)     hold_full <= 1'b1;
      else if (drain) hold_full <= 1'b0;
      ready_q <= ~(accept | hold_full);
    end
  end

  // Data path: held word and shift register.
  always_ff @(posedge r_clk) begin
    // NOTE: pure data registers are not reset; hold_full and the FSM decide when their contents matter.
    if (accept) hold_data <= tx_if.tx_data;
    if (drain)  shifter   <= {^hold_data, hold_data};
  end

  // Registered line outputs, aligned so busy and frame_done track tx_out.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      tx_out     <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx_out     <= line_bit;
      tx_busy    <= (state_q != IDLE);
      frame_done <= (state_q == STOP) && bit_end;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer at DIV=16: a line monitor decodes every
// frame and compares it with words queued at accept time.
module tb_uart_tx_serializer;

  localparam int DIV   = 16;
  localparam int NBITS = 11;

  logic r_clk = 1'b0;
  logic r_rst = 1'b1;
  logic tx_out, tx_busy, frame_done;

  uart_tx_serializer_if #(.WORD_LENGTH(8)) tx_if ();

  uart_tx_serializer #(
    .CLK_RATE(1600), .BAUD(100), .WORD_LENGTH(8)
  ) dut (
    .r_clk(r_clk), .r_rst(r_rst), .tx_if(tx_if),
    .tx_out(tx_out), .tx_busy(tx_busy), .frame_done(frame_done)
  );

  always #5 r_clk = ~r_clk;

  logic [7:0] exp_q[$];
  int n_checks = 0, n_pass = 0;
  int n_sent = 0, n_discarded = 0, frames_rx = 0;
  int cyc = 0, last_done_cyc = -10, contig = 0;
  bit in_frame = 0;

  always @(posedge r_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Offer one word from a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] d, input bit keep_valid);
    bit done = 0;
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (tx_if.tx_ready) begin
        exp_q.push_back(d);
        n_sent++;
        done = 1;
      end
      @(negedge r_clk);
    end
    if (!keep_valid) tx_if.tx_valid = 1'b0;
    if (!done) check("accept_timeout", 0, 1);
    else       check("ready_after_accept", tx_if.tx_ready, 0);
  endtask

  task automatic wait_drained();
    bit done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge r_clk);
      if (exp_q.size() == 0 && !in_frame && !tx_busy) done = 1;
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  // Line monitor: decodes frames, checks bit widths, busy and frame_done.
  initial begin : monitor
    logic [NBITS-1:0] bits;
    logic [7:0] exp;
    bit aborted;
    forever begin
      @(negedge r_clk);
      if (!r_rst) begin
        if (tx_out == 1'b0) begin
          in_frame = 1;
          aborted  = 0;
          bits     = '0;
          if (cyc == last_done_cyc + 1) contig++;
          for (int b = 0; b < NBITS && !aborted; b++) begin
            for (int c = 0; c < DIV && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge r_clk);
              if (r_rst) aborted = 1;
              else begin
                if (c == 0) bits[b] = tx_out;
                else        check("bit_width", tx_out, bits[b]);
                check("frame_done", frame_done, (b == NBITS-1 && c == DIV-1));
                check("busy_in_frame", tx_busy, 1);
                if (frame_done) last_done_cyc = cyc;
              end
            end
          end
          if (!aborted) begin
            frames_rx++;
            check("start_bit", bits[0], 0);
            check("stop_bit", bits[10], 1);
            if (exp_q.size() == 0) check("unexpected_frame", {24'h0, bits[8:1]}, 32'hFFFF_FFFF);
            else begin
              exp = exp_q.pop_front();
              check("data", bits[8:1], exp);
              check("parity", bits[9], ^exp);
            end
          end
          in_frame = 0;
        end else begin
          check("idle_busy", tx_busy, 0);
          check("idle_frame_done", frame_done, 0);
        end
      end
    end
  end

  initial begin : stim
    int c0;
    int accepted;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    repeat (3) @(negedge r_clk);
    check("rst_tx_out", tx_out, 1);
    check("rst_ready", tx_if.tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_frame_done", frame_done, 0);
    r_rst = 1'b0;
    repeat (3) @(negedge r_clk);

    // Accept latency: line falls two edges after accept, ready back with it.
    send(8'hA5, 0);
    check("lat_n_out", tx_out, 1);
    @(negedge r_clk);
    check("lat_n1_out", tx_out, 1);
    check("lat_n1_ready", tx_if.tx_ready, 0);
    @(negedge r_clk);
    check("lat_n2_out", tx_out, 0);
    check("lat_n2_ready", tx_if.tx_ready, 1);
    check("lat_n2_busy", tx_busy, 1);
    wait_drained();

    // Parity corner words, each sent from idle.
    send(8'h07, 0); wait_drained();
    send(8'h00, 0); wait_drained();
    send(8'hFF, 0); wait_drained();

    // Valid held across three words: frames must abut.
    c0 = contig;
    send(8'h11, 1);
    send(8'h22, 1);
    send(8'h33, 0);
    wait_drained();
    check("b2b_contig", contig - c0, 2);

    // Reset 40 cycles into a frame with a second word held.
    send(8'h3C, 0);
    repeat (2) @(negedge r_clk);
    send(8'hC3, 0);
    repeat (37) @(negedge r_clk);
    #2 r_rst = 1'b1;
    n_discarded += exp_q.size();
    exp_q.delete();
    #1;
    check("abort_tx_out", tx_out, 1);
    check("abort_ready", tx_if.tx_ready, 1);
    check("abort_busy", tx_busy, 0);
    repeat (3) @(negedge r_clk);
    r_rst = 1'b0;
    repeat (300) @(negedge r_clk);
    check("abort_discarded", n_discarded, 2);

    // Valid and data toggling randomly; only accepted words may appear.
    accepted = 0;
    for (int i = 0; i < 20000 && accepted < 30; i++) begin
      tx_if.tx_valid = 1'($urandom_range(0, 1));
      tx_if.tx_data  = 8'($urandom);
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        exp_q.push_back(tx_if.tx_data);
        n_sent++;
        accepted++;
      end
      @(negedge r_clk);
    end
    tx_if.tx_valid = 1'b0;
    check("random_accepts", accepted, 30);
    wait_drained();

    // Every byte value, back-to-back.
    c0 = contig;
    for (int w = 0; w < 256; w++) send(8'(w), (w != 255));
    wait_drained();
    check("sweep_contig", contig - c0, 255);

    repeat (5) @(negedge r_clk);
    check("frame_count", frames_rx, n_sent - n_discarded);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
